// File: rtl/input_frame_loader.sv
// input_frame_loader
//
// Loads a session of square frames from a byte stream into the input SRAM and
// starts the convolution engine when the session ends.
//
// Stream format: a header byte N (frame dimension), then N*N pixel bytes in
// row-major order. More frames may follow. A header byte of 0 ends the session.
// SRAM image: {8'h00,N} at the header slot, then N*N/2 packed pixel words
// (first byte of each pair in [15:8]), repeated per frame, and a 16'hFFFF
// terminator word at the end.
//
// Ports
//   clk                        clock, all flops on posedge
//   reset                      asynchronous active-high reset
//   load_start                 one-cycle pulse opening a session (IDLE only)
//   in_valid / in_data         byte stream, transfers when in_valid && in_ready
//   in_ready                   byte stream ready
//   input_sram_write_enable    registered SRAM write strobe
//   input_sram_write_addresss  registered SRAM write address
//   input_sram_write_data      registered SRAM write data
//   dut_run                    one-cycle engine start pulse after the terminator
//   load_busy                  session in progress
//   load_err                   sticky header-rejected flag
//   frame_count                frames written this session (saturates at 255)
//
// Build option
//   LOADER_FRAME_CHECK_EN      when defined, headers that are odd, below 4, above
//                              MAX_N, or that would overflow the SRAM are
//                              rejected: load_err is set and the session ends.

`timescale 1ns/1ps

module input_frame_loader #(
   parameter int unsigned MAX_N      = 64,
   parameter int unsigned SRAM_DEPTH = 4096
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load_start,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        input_sram_write_enable,
   output logic [11:0] input_sram_write_addresss,
   output logic [15:0] input_sram_write_data,
   output logic        dut_run,
   output logic        load_busy,
   output logic        load_err,
   output logic [7:0]  frame_count
);

   typedef enum logic [2:0] {StIdle, StHdr, StPixHi, StPixLo, StTerm, StDone} state_e;

`ifdef LOADER_FRAME_CHECK_EN
   localparam bit CheckEn = 1'b1;
`else
   localparam bit CheckEn = 1'b0;
`endif

   state_e      state_q;
   logic        rdy_q;
   logic        we_q;
   logic [11:0] addr_q;
   logic [15:0] data_q;
   logic        run_q;
   logic        busy_q;
   logic        err_q;
   logic [7:0]  fc_q;
   logic [11:0] ptr_q;
   logic [15:0] cnt_q;
   logic [7:0]  hi_q;

   // Header decode: words of pixel data that follow a header of value in_data.
   logic [15:0] hdr_n16;
   logic [15:0] hdr_words;
   logic [31:0] hdr_need;
   logic        hdr_fits;
   logic        hdr_bad;

   assign hdr_n16   = {8'd0, in_data};
   assign hdr_words = (hdr_n16 * hdr_n16) >> 1;
   // Slots needed from the pointer: header + pixel words + one terminator.
   assign hdr_need  = {20'd0, ptr_q} + {16'd0, hdr_words} + 32'd2;
   assign hdr_fits  = (hdr_need <= SRAM_DEPTH);
   // The checks are always computed; CheckEn masks them out in the default build.
   assign hdr_bad   = CheckEn & (in_data[0] | (in_data < 8'd4) |
                                 ({24'd0, in_data} > MAX_N) | ~hdr_fits);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         rdy_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         run_q   <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
         fc_q    <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
         hi_q    <= '0;
      end else begin
         we_q  <= 1'b0;
         run_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (load_start) begin
                  state_q <= StHdr;
                  rdy_q   <= 1'b1;
                  busy_q  <= 1'b1;
                  err_q   <= 1'b0;
                  fc_q    <= '0;
                  ptr_q   <= '0;
               end
            end
            StHdr: begin
               // in_ready is low for one cycle after each accepted byte that writes.
               if (!rdy_q) begin
                  rdy_q <= 1'b1;
               end else if (in_valid) begin
                  rdy_q <= 1'b0;
                  if (in_data == 8'd0) begin
                     state_q <= StTerm;
                  end else if (hdr_bad) begin
                     err_q   <= 1'b1;
                     state_q <= StTerm;
                  end else begin
                     we_q    <= 1'b1;
                     addr_q  <= ptr_q;
                     data_q  <= {8'h00, in_data};
                     ptr_q   <= ptr_q + 12'd1;
                     cnt_q   <= hdr_words;
                     state_q <= StPixHi;
                  end
               end
            end
            StPixHi: begin
               if (!rdy_q) begin
                  rdy_q <= 1'b1;
               end else if (in_valid) begin
                  hi_q    <= in_data;
                  state_q <= StPixLo;
               end
            end
            StPixLo: begin
               if (in_valid && rdy_q) begin
                  we_q   <= 1'b1;
                  addr_q <= ptr_q;
                  data_q <= {hi_q, in_data};
                  ptr_q  <= ptr_q + 12'd1;
                  cnt_q  <= cnt_q - 16'd1;
                  rdy_q  <= 1'b0;
                  if (cnt_q == 16'd1) begin
                     state_q <= StHdr;
                     if (fc_q != 8'hFF) begin
                        fc_q <= fc_q + 8'd1;
                     end
                  end else begin
                     state_q <= StPixHi;
                  end
               end
            end
            StTerm: begin
               // Terminator, engine start and busy drop all appear in the DONE cycle.
               we_q    <= 1'b1;
               addr_q  <= ptr_q;
               data_q  <= 16'hFFFF;
               ptr_q   <= ptr_q + 12'd1;
               run_q   <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= StDone;
            end
            StDone: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
               rdy_q   <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready                  = rdy_q;
   assign input_sram_write_enable   = we_q;
   assign input_sram_write_addresss = addr_q;
   assign input_sram_write_data     = data_q;
   assign dut_run                   = run_q;
   assign load_busy                 = busy_q;
   assign load_err                  = err_q;
   assign frame_count               = fc_q;

endmodule

// File: doc/input_frame_loader.md
INPUT_FRAME_LOADER -- requirements
Module: input_frame_loader

Interface
REQ-001 SHALL have parameter MAX_N, default 64, giving the largest accepted frame dimension.
REQ-002 SHALL have parameter SRAM_DEPTH, default 4096, giving the input SRAM word count.
REQ-003 SHALL have port clk  input  1  the single clock; all flops rise on posedge clk.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port load_start  input  1  one-cycle pulse that opens a load session.
REQ-006 SHALL have port in_valid  input  1  byte-stream valid.
REQ-007 SHALL have port in_data  input  8  byte-stream data.
REQ-008 SHALL have port in_ready  output  1  byte-stream ready; a byte transfers when in_valid and in_ready are both high.
REQ-009 SHALL have port input_sram_write_enable  output  1  input SRAM write strobe.
REQ-010 SHALL have port input_sram_write_addresss  output  12  input SRAM write address.
REQ-011 SHALL have port input_sram_write_data  output  16  input SRAM write data.
REQ-012 SHALL have port dut_run  output  1  one-cycle start pulse to the convolution engine.
REQ-013 SHALL have port load_busy  output  1  session in progress.
REQ-014 SHALL have port load_err  output  1  sticky; a header was rejected.
REQ-015 SHALL have port frame_count  output  8  count of frames written in this session.

Function
REQ-016 SHALL implement the states IDLE, HDR, PIX_HI, PIX_LO, TERM and DONE.
REQ-017 SHALL move IDLE->HDR on load_start, clear load_err, clear frame_count, set the write pointer to 0, and ignore load_start in all other states.
REQ-018 SHALL drive in_ready high only in HDR, PIX_HI and PIX_LO, and hold it low on the cycle that follows an accepted header byte or an accepted PIX_LO byte.
REQ-019 SHALL, in HDR, treat a nonzero accepted byte N as a frame header: write {8'h00,N} to the pointer, load word counter N*N/2, and go to PIX_HI.
REQ-020 SHALL, in HDR, treat an accepted byte 0 as end of session and go to TERM.
REQ-021 SHALL pack pixel bytes in row-major order, first byte into [15:8] and second into [7:0], and write one word per accepted PIX_LO byte.
REQ-022 SHALL decrement the word counter per write, return to HDR and increment frame_count (saturating at 255) when the counter reaches 0, and otherwise return to PIX_HI.
REQ-023 SHALL, in TERM, write 16'hFFFF at the pointer, then go to DONE.
REQ-024 SHALL, in DONE, pulse dut_run high for exactly one cycle, drop load_busy in that same cycle, and return to IDLE.
REQ-025 SHALL register all SRAM outputs: write_enable is high for one cycle, the cycle after the accepting byte (or the TERM cycle), with address equal to the pointer and the pointer incrementing after each write.
REQ-026 SHALL keep load_busy high from the cycle after load_start until the DONE cycle.
REQ-027 SHALL hold the state and any half-packed byte with no write when in_valid drops mid-frame (stall).

Reset
REQ-028 SHALL, while reset is high, force state IDLE and all outputs, pointer and counters to 0 regardless of clk.
REQ-029 SHALL abandon the session on reset mid-operation without a terminator write or dut_run, require a new load_start, and restart at address 0.

Configuration
REQ-030 SHALL support macro LOADER_FRAME_CHECK_EN.
REQ-031 SHALL, with LOADER_FRAME_CHECK_EN defined, reject any header that is odd, less than 4, greater than MAX_N, or that fails pointer+1+N*N/2+1 <= SRAM_DEPTH: set load_err and go to TERM, with the terminator written at the current pointer.
REQ-032 SHALL, without LOADER_FRAME_CHECK_EN defined, accept any nonzero header, tie load_err to 0, and leave behaviour undefined for malformed headers.

Verification
REQ-033 SHALL cover: start, header 4, bytes 0x01..0x10, header 0 -> addr0=0x0004, addr1=0x0102 .. addr8=0x0F10, addr9=0xFFFF, then dut_run one-cycle pulse, frame_count=1.
REQ-034 SHALL cover: headers 4 then 6 with full pixel data, then 0 -> second header at addr9=0x0006, terminator at addr28, frame_count=2.
REQ-035 SHALL cover: scenario REQ-033 with in_valid low every other cycle -> identical SRAM writes, no write during stalls.
REQ-036 SHALL cover, with the macro defined: header 5 -> load_err=1, 0xFFFF at addr0, dut_run pulse; header 66 gives the same result.
REQ-037 SHALL cover, with the macro defined: header 64 twice -> first frame occupies addr0..2048, second header rejected, 0xFFFF at addr2049, load_err=1.
REQ-038 SHALL cover: reset asserted mid-frame at header 4, byte 7 -> all outputs 0 immediately, no dut_run; a new session writes 0x0004 at addr0.
